// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder sequencer driving one external 4-bit adder slice.
// Adds two 4*NIBBLES-bit operands one nibble per clock and pulses done.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_sum,
   input  logic                   add_cout
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    work_q, work_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            done_q, done_d;
   logic            last;

   assign last = (idx_q == IW'(NIBBLES - 1));

   // Present the current nibble pair and running carry to the slice
   always_comb begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
      if (state_q == RUN) begin
         add_a   = a_q[4*idx_q +: 4];
         add_b   = b_q[4*idx_q +: 4];
         add_cin = carry_q;
      end
   end

   // Next-state logic: accept in IDLE, capture one nibble per RUN cycle
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      work_d  = work_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            work_d[4*idx_q +: 4] = add_sum;
            carry_d = add_cout;
            if (last) begin
               sum_d   = work_d;
               cout_d  = add_cout;
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; reset aborts any add in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder with a modelled 4-bit slice.
// Reference model works at transaction level from a + b + cin.
module tb_nibble_serial_adder;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  a, b;
   logic          cin;
   logic          busy, done, cout;
   logic [W-1:0]  sum;
   logic [3:0]    add_a, add_b, add_sum;
   logic          add_cin, add_cout;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // 4-bit full-adder slice
   assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Transaction-level model: remaining nibble cycles and latched operands
   int           m_rem;
   logic [W-1:0] m_a, m_b, m_sum;
   logic         m_cin, m_cout, m_done;

   always @(posedge clk) begin
      if (rst) begin
         m_rem  <= 0;
         m_sum  <= '0;
         m_cout <= 1'b0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_rem == 0) begin
            if (start) begin
               m_a   <= a;
               m_b   <= b;
               m_cin <= cin;
               m_rem <= NIBBLES;
            end
         end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               {m_cout, m_sum} <= (W+1)'(m_a) + (W+1)'(m_b) + (W+1)'(m_cin);
               m_done <= 1'b1;
            end
         end
      end
   end

   // Compare every cycle, away from the rising edge
   always @(negedge clk) begin
      if (chk_en) begin
         int k;
         logic [W:0] lo;
         logic [W:0] part;
         logic [3:0] ea, eb;
         logic       ec;
         ea = 4'h0;
         eb = 4'h0;
         ec = 1'b0;
         if (m_rem > 0) begin
            k    = NIBBLES - m_rem;
            lo   = ~({(W+1){1'b1}} << (4 * k));
            ea   = 4'({1'b0, m_a} >> (4 * k));
            eb   = 4'({1'b0, m_b} >> (4 * k));
            part = ({1'b0, m_a} & lo) + ({1'b0, m_b} & lo) + (W+1)'(m_cin);
            ec   = part[4*k];
         end
         chk("busy", 64'(busy), 64'(m_rem > 0));
         chk("done", 64'(done), 64'(m_done));
         chk("sum", 64'(sum), 64'(m_sum));
         chk("cout", 64'(cout), 64'(m_cout));
         chk("add_a", 64'(add_a), 64'(ea));
         chk("add_b", 64'(add_b), 64'(eb));
         chk("add_cin", 64'(add_cin), 64'(ec));
      end
   end

   // Issue one add from the current point (start sampled on next edge),
   // optionally re-pulse start in RUN cycle inj; returns at the done cycle.
   task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic [W-1:0] es,
                         input logic ec, input int inj, input bit lit,
                         output logic [NIBBLES-1:0] ctrace);
      int n;
      int bc;
      n  = 0;
      bc = 0;
      ctrace = '0;
      start = 1'b1;
      a = ta;
      b = tb;
      cin = tc;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      forever begin
         @(negedge clk);
         if (busy) begin
            if (bc < NIBBLES) ctrace[bc] = add_cin;
            bc++;
         end
         if (done) break;
         n++;
         if (n > 3 * NIBBLES + 4) begin
            chk("done_timeout", 64'(n), 64'(NIBBLES));
            return;
         end
         @(posedge clk);
         #1;
         start = (inj != 0) && (bc == inj - 1);
         if (start) begin
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
         end
      end
      if (lit) begin
         chk("latency", 64'(n), 64'(NIBBLES));
         chk("busy_cycles", 64'(bc), 64'(NIBBLES));
         chk("lit_sum", 64'(sum), 64'(es));
         chk("lit_cout", 64'(cout), 64'(ec));
      end
   endtask

   initial begin
      logic [NIBBLES-1:0] tr;
      logic [W-1:0]       ra, rb;
      logic               rc;
      logic [W:0]         rs;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 1'b1, tr);
      do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b1, tr);
      chk("ripple_cin", 64'(tr), 64'(4'b1110));
      do_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, 1'b1, tr);
      do_add(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 0, 1'b1, tr);
      do_add(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 2, 1'b1, tr);

      @(posedge clk);
      #1;
      start = 1'b1;
      a = 16'hAAAA;
      b = 16'h5555;
      cin = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      repeat (6) begin
         @(negedge clk);
         chk("abort_no_done", 64'(done), 64'd0);
      end
      @(posedge clk);
      #1;
      do_add(16'h8001, 16'h7FFF, 1'b0, 16'h0000, 1'b1, 0, 1'b1, tr);

      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         do_add(ra, rb, rc, rs[W-1:0], rs[W],
                int'($urandom_range(0, NIBBLES)), 1'b1, tr);
      end

      @(posedge clk);
      #1;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
